// File: rtl/seg_pkg.sv
// Seven-segment pattern reader: shared constants, pattern table, filter state and output word type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package seg_pkg;

  // Segment bit positions in the active-high pattern; 1..5 run clockwise from top-right.
  localparam int SEG_TOP = 0;
  localparam int SEG_TR  = 1;
  localparam int SEG_BR  = 2;
  localparam int SEG_BOT = 3;
  localparam int SEG_BL  = 4;
  localparam int SEG_TL  = 5;
  localparam int SEG_MID = 6;

  localparam int SEG_W = 7;

  // Active-high segment patterns for hex digits 0..F, indexed by digit value.
  localparam logic [SEG_W-1:0] SEG_PATTERN [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } reader_state_t;

  // Classified output word as carried by the output buffer.
  typedef struct packed {
    logic [3:0] digit;
    logic       blank;
    logic       pattern_error;
  } seg_word_t;

endpackage

// File: rtl/seg_pattern_reader_if.sv
// Bundle of the segment input bus, enable and the valid/ready digit output of the reader.
// Latency: none (wiring only).
// Backpressure: digit_ready from the consumer holds digit_valid and its word.
interface seg_pattern_reader_if;
  logic [6:0] segments_n;
  logic       enable;
  logic       digit_ready;
  logic [3:0] digit;
  logic       digit_valid;
  logic       blank;
  logic       pattern_error;
  logic       overrun;

  // Reader side: samples the bus, drives the classified word.
  modport master (
    input  segments_n, enable, digit_ready,
    output digit, digit_valid, blank, pattern_error, overrun
  );

  // Environment side: drives the bus and consumes words.
  modport slave (
    output segments_n, enable, digit_ready,
    input  digit, digit_valid, blank, pattern_error, overrun
  );
endinterface

// File: rtl/seg_pattern_lookup.sv
// Classifies an active-high segment pattern as hex digit, blank or illegal pattern.
// Latency: combinational.
// Backpressure: none.
module seg_pattern_lookup
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] s,
  output seg_word_t        word
);

  // Table search; patterns are unique so at most one entry can match.
  always_comb begin
    word = '0;
    if (s == SEG_BLANK) begin
      word.blank = 1'b1;
    end else begin
      word.pattern_error = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (s == SEG_PATTERN[i]) begin
          word.digit         = 4'(i);
          word.pattern_error = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg_pattern_reader.sv
// Recovers hex digits from an async active-low seven-segment bus: sync, stability filter, classify, 1-entry buffer.
// Latency: bus change before edge k gives digit_valid after edge k+1+STABLE_CYCLES.
// Backpressure: word held until digit_ready; a new acceptance overwrites a pending word and sets sticky overrun.
module seg_pattern_reader
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  seg_pattern_reader_if.master bus
);

  // cnt holds (run length - 1): a changed sample restarts the run at 0.
  localparam logic [7:0] RUN_LAST = 8'(STABLE_CYCLES - 1);

  logic [SEG_W-1:0] sync1_q, sync1_d;
  logic [SEG_W-1:0] p_q, p_d;
  logic [SEG_W-1:0] p_prev_q, p_prev_d;
  logic [SEG_W-1:0] last_q, last_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             have_last_q, have_last_d;
  reader_state_t    state_q, state_d;
  seg_word_t        word_q, word_d;
  seg_word_t        lookup_word;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             accept;

  // Two-flop synchronizer on the inverted (active-high) bus.
  always_comb begin
    sync1_d = ~bus.segments_n;
    p_d     = sync1_q;
  end

  // Synchronizer registers; reset value matches the all-off bus.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      p_q     <= '0;
    end else begin
      sync1_q <= sync1_d;
      p_q     <= p_d;
    end
  end

  // Stability filter: run counter, LOCKED/SETTLE tracking and acceptance of new patterns.
  always_comb begin
    p_prev_d    = p_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    accept      = 1'b0;

    if (!bus.enable || (p_q != p_prev_q)) begin
      cnt_d = '0;
    end else if (cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end

    case (state_q)
      LOCKED: begin
        if (!bus.enable || (p_q != last_q)) begin
          state_d = SETTLE;
        end
      end
      default: ;
    endcase

    // A run that just reached its length is accepted only if it differs from the last accepted
    // pattern; this also covers a change seen in LOCKED when a single sample suffices.
    if (bus.enable && (cnt_d == RUN_LAST) && (!have_last_q || (p_q != last_q))) begin
      accept      = 1'b1;
      state_d     = LOCKED;
      last_d      = p_q;
      have_last_d = 1'b1;
    end
  end

  // Filter state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_prev_q    <= '0;
      cnt_q       <= '0;
      state_q     <= SETTLE;
      last_q      <= '0;
      have_last_q <= 1'b0;
    end else begin
      p_prev_q    <= p_prev_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
    end
  end

  seg_pattern_lookup u_lookup (
    .s    (p_q),
    .word (lookup_word)
  );

  // One-entry output buffer; a same-cycle consume and load keeps valid high without overrun.
  always_comb begin
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (accept) begin
      if (valid_q && !bus.digit_ready) begin
        overrun_d = 1'b1;
      end
      word_d  = lookup_word;
      valid_d = 1'b1;
    end else if (bus.digit_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output buffer registers; every output comes straight from these flops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.digit         = word_q.digit;
  assign bus.blank         = word_q.blank;
  assign bus.pattern_error = word_q.pattern_error;
  assign bus.digit_valid   = valid_q;
  assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_seg_pattern_reader.sv
// Bench for seg_pattern_reader: directed scenarios plus random bus activity against a reference model.
// Latency: model predicts outputs after every rising edge.
// Backpressure: digit_ready driven directly and randomly.
`timescale 1ns/1ps
module tb_seg_pattern_reader;

  localparam int S = 4;
  localparam logic [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk = 1'b0;
  logic reset_n;

  seg_pattern_reader_if bus ();

  seg_pattern_reader #(.STABLE_CYCLES(S)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state: word = {digit, blank, pattern_error}.
  logic [6:0] m_d1, m_d2;
  logic [6:0] hist_p[$];
  bit         hist_brk[$];
  bit         m_have_last;
  logic [6:0] m_last;
  logic       m_vld, m_ovr;
  logic [5:0] m_word;
  logic [5:0] dut_words[$];

  function automatic logic [5:0] classify(input logic [6:0] s);
    if (s == 7'h00) return 6'b0000_10;
    for (int i = 0; i < 16; i++) begin
      if (PAT[i] == s) return {i[3:0], 2'b00};
    end
    return 6'b0000_01;
  endfunction

  function automatic logic [5:0] dut_word();
    return {bus.digit, bus.blank, bus.pattern_error};
  endfunction

  // Predict the coming edge from the applied inputs, take the edge, compare one step later.
  task automatic tick();
    logic [6:0] p;
    int         run;
    bit         acc;
    if (bus.digit_valid && bus.digit_ready && reset_n) dut_words.push_back(dut_word());
    if (!reset_n) begin
      m_d1 = '0; m_d2 = '0;
      hist_p.delete(); hist_brk.delete();
      hist_p.push_back(7'h00); hist_brk.push_back(1'b1);
      m_have_last = 1'b0; m_last = '0;
      m_vld = 1'b0; m_ovr = 1'b0; m_word = '0;
    end else begin
      p    = m_d2;
      m_d2 = m_d1;
      m_d1 = ~bus.segments_n;
      hist_brk.push_back(!bus.enable || (p != hist_p[$]));
      hist_p.push_back(p);
      if (hist_p.size() > 600) begin
        void'(hist_p.pop_front());
        void'(hist_brk.pop_front());
      end
      run = 0;
      for (int i = hist_p.size() - 1; i >= 0; i--) begin
        run++;
        if (hist_brk[i]) break;
      end
      acc = bus.enable && (run == S) && (!m_have_last || (p != m_last));
      if (acc) begin
        m_have_last = 1'b1;
        m_last      = p;
        if (m_vld && !bus.digit_ready) m_ovr = 1'b1;
        m_word = classify(p);
        m_vld  = 1'b1;
      end else if (bus.digit_ready) begin
        m_vld = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("out", {23'd0, bus.digit_valid, dut_word(), bus.overrun, 1'b0},
                 {23'd0, m_vld, m_word, m_ovr, 1'b0});
  endtask

  task automatic hold(input logic [6:0] pat, input int cycles);
    bus.segments_n = ~pat;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    int         first;
    int         highs;
    logic [5:0] w;

    reset_n         = 1'b0;
    bus.segments_n  = ~7'h5B;
    bus.enable      = 1'b1;
    bus.digit_ready = 1'b1;
    tick();
    tick();
    check("reset_out", {bus.digit_valid, bus.digit, bus.blank, bus.pattern_error, bus.overrun}, 8'h00);

    // Latency and single delivery of digit 2.
    reset_n = 1'b1;
    first = -1; highs = 0; w = '0;
    for (int j = 0; j < 15; j++) begin
      tick();
      if (bus.digit_valid) begin
        highs++;
        if (first < 0) begin first = j; w = dut_word(); end
      end
    end
    check("t1_latency", first, 5);
    check("t1_highs", highs, 1);
    check("t1_word", w, {4'd2, 2'b00});

    // All sixteen digits in order.
    dut_words.delete();
    for (int d = 0; d < 16; d++) hold(PAT[d], 10);
    tick();
    check("t2_count", dut_words.size(), 16);
    for (int d = 0; d < 16 && d < dut_words.size(); d++)
      check("t2_word", dut_words[d], {d[3:0], 2'b00});

    // Short glitches of 1 inside a held 0.
    dut_words.delete();
    hold(7'h3F, 20);
    hold(7'h06, 3);
    hold(7'h3F, 20);
    hold(7'h06, 3);
    hold(7'h3F, 20);
    check("t3_count", dut_words.size(), 1);
    if (dut_words.size() > 0) check("t3_word", dut_words[0], {4'd0, 2'b00});

    // Illegal pattern then blank.
    dut_words.delete();
    hold(7'h49, 10);
    hold(7'h00, 10);
    check("t4_count", dut_words.size(), 2);
    if (dut_words.size() > 1) begin
      check("t4_err", dut_words[0], 6'b0000_01);
      check("t4_blank", dut_words[1], 6'b0000_10);
    end

    // Overwrite of a pending word.
    bus.digit_ready = 1'b0;
    hold(PAT[7], 10);
    hold(PAT[8], 10);
    check("t5_pending", {bus.digit_valid, bus.digit, bus.overrun}, {1'b1, 4'd8, 1'b1});
    bus.digit_ready = 1'b1;
    tick();
    check("t5_drained", {bus.digit_valid, bus.overrun}, 2'b01);

    // Reset with a word pending and the filter mid-count.
    bus.digit_ready = 1'b0;
    hold(PAT[3], 10);
    hold(PAT[5], 3);
    reset_n = 1'b0;
    tick();
    check("t6_reset_out", {bus.digit_valid, bus.digit, bus.blank, bus.pattern_error, bus.overrun}, 8'h00);
    reset_n = 1'b1;
    first = -1; w = '0;
    for (int j = 0; j < 15; j++) begin
      tick();
      if (bus.digit_valid && first < 0) begin first = j; w = dut_word(); end
    end
    check("t6_latency", first, 5);
    check("t6_word", w, {4'd5, 2'b00});

    // Random bus activity, enable and backpressure, with occasional resets.
    for (int n = 0; n < 300; n++) begin
      int         r;
      logic [6:0] pat;
      r = $urandom_range(0, 9);
      if (r < 6)       pat = PAT[$urandom_range(0, 15)];
      else if (r == 6) pat = 7'h00;
      else             pat = 7'($urandom_range(0, 127));
      bus.segments_n = ~pat;
      bus.enable     = ($urandom_range(0, 9) != 0);
      reset_n        = ($urandom_range(0, 59) != 0);
      for (int c = $urandom_range(1, 10); c > 0; c--) begin
        bus.digit_ready = ($urandom_range(0, 3) != 0);
        tick();
        reset_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
